// File: rtl/scrub_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// scrub_scheduler
//
// Triple-modular-redundant register array with a background scrubber.
// Every entry is stored in three copies (A, B, C). Reads return the bitwise
// majority of the three copies. A slow scrubber walks the array one entry per
// step (INTERVAL idle cycles, one READ cycle, one FIX cycle). It repairs any
// entry whose copies disagree and counts the repairs.
//
// Parameters
//   M         number of entries
//   W         entry width in bits
//   INTERVAL  idle cycles between scrub steps (>= 1)
//
// Ports
//   clock       rising-edge clock
//   rst         asynchronous active-high reset
//   wr_en       host write strobe; writes wr_data to all three copies of wr_idx
//   wr_idx      host write index
//   wr_data     host write data
//   inj_en      fault-injection strobe
//   inj_copy    copy to corrupt (0=A, 1=B, 2=C, 3=ignored)
//   inj_idx     entry to corrupt
//   inj_mask    bits XORed into the selected copy
//   rd_idx      read index
//   rd_data     bitwise majority of the copies at rd_idx; 0 when out of range
//   scrub_idx   entry the scrubber is currently processing
//   err_cnt     saturating count of repaired entries
//   scrub_done  one-cycle pulse after the scrubber wraps from M-1 to 0
// -----------------------------------------------------------------------------
module scrub_scheduler #(
    parameter int M        = 4,
    parameter int W        = 8,
    parameter int INTERVAL = 4,
    localparam int IW      = (M > 1) ? $clog2(M) : 1
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic [W-1:0]  wr_data,
    input  logic          inj_en,
    input  logic [1:0]    inj_copy,
    input  logic [IW-1:0] inj_idx,
    input  logic [W-1:0]  inj_mask,
    input  logic [IW-1:0] rd_idx,
    output logic [W-1:0]  rd_data,
    output logic [IW-1:0] scrub_idx,
    output logic [7:0]    err_cnt,
    output logic          scrub_done
);

    localparam int CW = $clog2(INTERVAL + 1);
    localparam logic [IW:0] M_EXT = (IW + 1)'(M);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] interval_cnt;

    logic [W-1:0] copy_a [M];
    logic [W-1:0] copy_b [M];
    logic [W-1:0] copy_c [M];

    logic [W-1:0] next_a [M];
    logic [W-1:0] next_b [M];
    logic [W-1:0] next_c [M];

    logic [W-1:0] held_a_p1;
    logic [W-1:0] held_b_p1;
    logic [W-1:0] held_c_p1;
    logic         cancel_p1;

    logic         host_hit;
    logic         held_mismatch;
    logic [W-1:0] held_maj;
    logic         fix_write;

    function automatic logic [W-1:0] maj3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // A host write to the entry under scrub makes the latched copies stale,
    // so the repair for that entry is abandoned.
    assign host_hit      = wr_en && (wr_idx == scrub_idx);
    assign held_mismatch = (held_a_p1 != held_b_p1) || (held_b_p1 != held_c_p1);
    assign held_maj      = maj3(held_a_p1, held_b_p1, held_c_p1);
    assign fix_write     = (state == FIX) && held_mismatch && !cancel_p1 && !host_hit;

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < M_EXT) begin
            rd_data = maj3(copy_a[rd_idx], copy_b[rd_idx], copy_c[rd_idx]);
        end
    end

    // Per-entry next value: host write overrides everything for its entry;
    // otherwise the scrub repair lands first and an injection is applied on
    // top of it, so a fault injected during a repair is never lost.
    always_comb begin
        for (int i = 0; i < M; i++) begin
            next_a[i] = copy_a[i];
            next_b[i] = copy_b[i];
            next_c[i] = copy_c[i];
            if (wr_en && (wr_idx == IW'(i))) begin
                next_a[i] = wr_data;
                next_b[i] = wr_data;
                next_c[i] = wr_data;
            end else begin
                if (fix_write && (scrub_idx == IW'(i))) begin
                    next_a[i] = held_maj;
                    next_b[i] = held_maj;
                    next_c[i] = held_maj;
                end
                if (inj_en && (inj_idx == IW'(i))) begin
                    case (inj_copy)
                        2'd0:    next_a[i] = next_a[i] ^ inj_mask;
                        2'd1:    next_b[i] = next_b[i] ^ inj_mask;
                        2'd2:    next_c[i] = next_c[i] ^ inj_mask;
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                copy_a[i] <= '0;
                copy_b[i] <= '0;
                copy_c[i] <= '0;
            end
        end else begin
            for (int i = 0; i < M; i++) begin
                copy_a[i] <= next_a[i];
                copy_b[i] <= next_b[i];
                copy_c[i] <= next_c[i];
            end
        end
    end

    // READ -> FIX boundary: snapshot of the three copies under scrub
    always_ff @(posedge clock) begin
        if (state == READ) begin
            held_a_p1 <= copy_a[scrub_idx];
            held_b_p1 <= copy_b[scrub_idx];
            held_c_p1 <= copy_c[scrub_idx];
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            interval_cnt <= CW'(INTERVAL);
            scrub_idx    <= '0;
            err_cnt      <= '0;
            scrub_done   <= 1'b0;
            cancel_p1    <= 1'b0;
        end else begin
            scrub_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (interval_cnt <= CW'(1)) begin
                        state <= READ;
                    end else begin
                        interval_cnt <= interval_cnt - CW'(1);
                    end
                end
                READ: begin
                    cancel_p1 <= host_hit;
                    state     <= FIX;
                end
                FIX: begin
                    if (fix_write && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    state        <= IDLE;
                    interval_cnt <= CW'(INTERVAL);
                    if (scrub_idx == IW'(M - 1)) begin
                        scrub_idx  <= '0;
                        scrub_done <= 1'b1;
                    end else begin
                        scrub_idx <= scrub_idx + IW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scrub_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_scrub_scheduler
//
// Directed bench for scrub_scheduler (M=4, W=8, INTERVAL=4). A reference model
// tracks the three copies and derives the scrub schedule purely from the
// number of clock edges since reset (step period INTERVAL+2). A compare
// process checks every DUT output against it each cycle; directed scenarios
// add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_scrub_scheduler;

    localparam int M        = 4;
    localparam int W        = 8;
    localparam int INTERVAL = 4;
    localparam int P        = INTERVAL + 2;
    localparam int PASS     = M * P;

    logic       clock;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [7:0] wr_data;
    logic       inj_en;
    logic [1:0] inj_copy;
    logic [1:0] inj_idx;
    logic [7:0] inj_mask;
    logic [1:0] rd_idx;
    logic [7:0] rd_data;
    logic [1:0] scrub_idx;
    logic [7:0] err_cnt;
    logic       scrub_done;

    int vectors     = 0;
    int miscompares = 0;

    scrub_scheduler #(.M(M), .W(W), .INTERVAL(INTERVAL)) dut (
        .clock      (clock),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .inj_en     (inj_en),
        .inj_copy   (inj_copy),
        .inj_idx    (inj_idx),
        .inj_mask   (inj_mask),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .scrub_idx  (scrub_idx),
        .err_cnt    (err_cnt),
        .scrub_done (scrub_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void check(input string name, input logic [31:0] actual,
                                  input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endfunction

    function automatic logic [7:0] vote(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] r;
        int n;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            n = int'(a[k]) + int'(b[k]) + int'(c[k]);
            r[k] = (n >= 2);
        end
        return r;
    endfunction

    // ---------------- reference model ----------------
    logic [7:0] ma [M];
    logic [7:0] mb [M];
    logic [7:0] mc [M];
    logic [7:0] ha, hb, hc, mj, m_err;
    bit         m_cancel, m_done, hit, wb;
    int         m_t, pos, sidx;

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < M; e++) begin
                ma[e] = 8'h00;
                mb[e] = 8'h00;
                mc[e] = 8'h00;
            end
            m_err    = 8'd0;
            m_done   = 1'b0;
            m_cancel = 1'b0;
            m_t      = 0;
        end else begin
            pos    = m_t % P;
            sidx   = (m_t / P) % M;
            hit    = wr_en && (int'(wr_idx) == sidx);
            wb     = 1'b0;
            mj     = 8'h00;
            m_done = 1'b0;
            if (pos == INTERVAL) begin
                ha       = ma[sidx];
                hb       = mb[sidx];
                hc       = mc[sidx];
                m_cancel = hit;
            end
            if (pos == INTERVAL + 1) begin
                if (!(ha == hb && hb == hc) && !m_cancel && !hit) begin
                    wb = 1'b1;
                    mj = vote(ha, hb, hc);
                    if (m_err < 8'd255) m_err = m_err + 8'd1;
                end
                m_done = (sidx == M - 1);
            end
            for (int e = 0; e < M; e++) begin
                if (wr_en && int'(wr_idx) == e) begin
                    ma[e] = wr_data;
                    mb[e] = wr_data;
                    mc[e] = wr_data;
                end else begin
                    if (wb && e == sidx) begin
                        ma[e] = mj;
                        mb[e] = mj;
                        mc[e] = mj;
                    end
                    if (inj_en && int'(inj_idx) == e) begin
                        if (inj_copy == 2'd0) ma[e] = ma[e] ^ inj_mask;
                        if (inj_copy == 2'd1) mb[e] = mb[e] ^ inj_mask;
                        if (inj_copy == 2'd2) mc[e] = mc[e] ^ inj_mask;
                    end
                end
            end
            m_t = m_t + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        int cyc;
        int last;
        cyc  = 0;
        last = -1;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            check("rd_data", rd_data, vote(ma[rd_idx], mb[rd_idx], mc[rd_idx]));
            check("scrub_idx", scrub_idx, (m_t / P) % M);
            check("err_cnt", err_cnt, m_err);
            check("scrub_done", scrub_done, m_done);
            if (rst) begin
                last = -1;
            end else if (scrub_done) begin
                if (last >= 0) check("done_period", cyc - last, 24);
                last = cyc;
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic wait_phase(input int idx, input int ph);
        int n;
        n = 0;
        @(negedge clock);
        while (!((m_t % P) == ph && ((m_t / P) % M) == idx)) begin
            @(negedge clock);
            n++;
            if (n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_phase: entry %0d phase %0d not reached", idx, ph);
                return;
            end
        end
    endtask

    task automatic wait_pos0();
        int n;
        n = 0;
        @(negedge clock);
        while ((m_t % P) != 0) begin
            @(negedge clock);
            n++;
            if (n > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL wait_pos0: step start not reached");
                return;
            end
        end
    endtask

    task automatic do_write(input logic [1:0] idx, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = data;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic do_inj(input logic [1:0] cp, input logic [1:0] idx, input logic [7:0] mask);
        inj_en   = 1'b1;
        inj_copy = cp;
        inj_idx  = idx;
        inj_mask = mask;
        @(negedge clock);
        inj_en   = 1'b0;
    endtask

    task automatic check_copies(input string name, input int idx, input logic [7:0] exp);
        check({name, "_a"}, dut.copy_a[idx], exp);
        check({name, "_b"}, dut.copy_b[idx], exp);
        check({name, "_c"}, dut.copy_c[idx], exp);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] mask;
        int         cur;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;
        inj_en   = 1'b0;
        inj_copy = '0;
        inj_idx  = '0;
        inj_mask = '0;
        rd_idx   = '0;
        repeat (3) @(negedge clock);
        check("reset_err", err_cnt, 8'd0);
        check("reset_idx", scrub_idx, 2'd0);
        check("reset_done", scrub_done, 1'b0);
        for (int e = 0; e < M; e++) check_copies("reset_copy", e, 8'h00);
        rst = 1'b0;

        // Host writes, immediate read-back, two clean passes
        do_write(2'd0, 8'h11);
        do_write(2'd1, 8'hA5);
        do_write(2'd2, 8'h5A);
        rd_idx = 2'd2;
        #1 check("rd_after_write", rd_data, 8'h5A);
        @(negedge clock);
        do_write(2'd3, 8'hC3);
        repeat (2 * PASS) @(negedge clock);
        check("err_two_passes", err_cnt, 8'd0);

        // Single-copy fault on entry 1
        wait_phase(3, 0);
        rd_idx = 2'd1;
        do_inj(2'd1, 2'd1, 8'h0F);
        #1 check("rd_masked_b", rd_data, 8'hA5);
        wait_phase(2, 0);
        check("err_single", err_cnt, 8'd1);
        check_copies("fixed_e1", 1, 8'hA5);

        // Disjoint faults in copies A and B of entry 0
        wait_phase(3, 0);
        do_inj(2'd0, 2'd0, 8'h01);
        do_inj(2'd1, 2'd0, 8'h10);
        rd_idx = 2'd0;
        #1 check("rd_two_faults", rd_data, 8'h11);
        wait_phase(1, 0);
        check("err_two_faults", err_cnt, 8'd2);
        check_copies("fixed_e0", 0, 8'h11);

        // Host writes cancel repairs (during READ of 2, during FIX of 3)
        do_inj(2'd2, 2'd2, 8'hFF);
        do_inj(2'd2, 2'd3, 8'h0C);
        wait_phase(2, INTERVAL);
        do_write(2'd2, 8'h33);
        wait_phase(3, INTERVAL + 1);
        do_write(2'd3, 8'h3C);
        wait_phase(0, 0);
        rd_idx = 2'd2;
        #1 check("rd_cancel_read", rd_data, 8'h33);
        rd_idx = 2'd3;
        #1 check("rd_cancel_fix", rd_data, 8'h3C);
        check("err_cancelled", err_cnt, 8'd2);
        check_copies("cancel_e2", 2, 8'h33);

        // Same-entry write beats injection; copy 3 ignored; concurrent ops
        @(negedge clock);
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 8'h77;
        inj_en = 1'b1; inj_idx = 2'd1; inj_copy = 2'd0; inj_mask = 8'hFF;
        @(negedge clock);
        wr_en = 1'b0; inj_en = 1'b0;
        do_inj(2'd3, 2'd0, 8'hFF);
        do_inj(2'd2, 2'd2, 8'h03);
        wait_phase(2, INTERVAL + 1);
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 8'h22;
        inj_en = 1'b1; inj_idx = 2'd3; inj_copy = 2'd0; inj_mask = 8'h80;
        @(negedge clock);
        wr_en = 1'b0; inj_en = 1'b0;
        check("err_concurrent", err_cnt, 8'd3);
        check_copies("prec_e1", 1, 8'h77);
        check_copies("conc_e0", 0, 8'h22);
        check_copies("conc_e2", 2, 8'h33);
        check("conc_e3_a", dut.copy_a[3], 8'hBC);
        wait_phase(0, 0);
        check("err_e3_fixed", err_cnt, 8'd4);
        check_copies("fixed_e3", 3, 8'h3C);

        // 300 injections, one per scrub step, each repaired in the same step
        for (int i = 0; i < 300; i++) begin
            wait_pos0();
            cur  = (m_t / P) % M;
            mask = 8'(1 << (i % 8));
            do_inj(2'(i % 3), 2'(cur), mask);
        end
        wait_pos0();
        check("err_saturated", err_cnt, 8'd255);

        // Reset during FIX of entry 3 with a repair pending
        wait_phase(3, 0);
        do_inj(2'd1, 2'd3, 8'h55);
        wait_phase(3, INTERVAL + 1);
        rst    = 1'b1;
        rd_idx = 2'd3;
        #1;
        check("rst_fix_idx", scrub_idx, 2'd0);
        check("rst_fix_err", err_cnt, 8'd0);
        check("rst_fix_done", scrub_done, 1'b0);
        check("rst_fix_rd", rd_data, 8'h00);
        for (int e = 0; e < M; e++) check_copies("rst_fix_copy", e, 8'h00);
        @(negedge clock);
        rst = 1'b0;
        inj_en = 1'b1; inj_idx = 2'd0; inj_copy = 2'd0; inj_mask = 8'h01;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) inj_en = 1'b0;
            if (k == 5) check("post_rst_before_fix", err_cnt, 8'd0);
            if (k == 6) check("post_rst_after_fix", err_cnt, 8'd1);
        end
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
